// File: rtl/niosii_system_button_pio.sv
// niosii_system_button_pio
// Avalon-MM input PIO for push-buttons/switches: synchroniser, optional per-bit
// debounce, per-bit rising/falling edge selection, write-1-to-clear edge capture
// and a maskable level interrupt.
// Optional feature macro: BUTTON_PIO_DEBOUNCE_EN (defined -> per-bit debounce
// counters between the synchroniser and the stable value).
module niosii_system_button_pio #(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    typedef enum logic [2:0] {
        ADDR_DATA     = 3'd0,
        ADDR_RISE_EN  = 3'd1,
        ADDR_IRQ_MASK = 3'd2,
        ADDR_CAPTURE  = 3'd3,
        ADDR_FALL_EN  = 3'd4
    } reg_addr_t;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_out;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] hit;
    logic [WIDTH-1:0] rise_en;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] capture;
    logic [WIDTH-1:0] fall_en;
    logic [WIDTH-1:0] wr_bits;
    logic [WIDTH-1:0] rd_sel;
    logic             wr_en;
    reg_addr_t        addr_dec;
    logic             unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign wr_bits      = writedata[WIDTH-1:0];
    assign addr_dec     = reg_addr_t'(address);
    assign unused_wdata = ^writedata;

    // Synchroniser chain for the raw asynchronous inputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= in_port;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef BUTTON_PIO_DEBOUNCE_EN
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] db_cnt [WIDTH];
    logic [WIDTH-1:0] stable_q;

    // Per-bit debounce: accept a new level only after it persists long enough
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_q <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (sync_out[i] == stable_q[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    stable_q[i] <= sync_out[i];
                    db_cnt[i]   <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign stable = stable_q;
`else
    // Last synchroniser flop is the stable value, giving stable after edge
    // k+SYNC_STAGES-1 and capture at edge k+SYNC_STAGES.
    assign stable = sync_out;
`endif

    // Delayed copy of the stable value for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_d <= '0;
        end else begin
            stable_d <= stable;
        end
    end

    assign rise = stable & ~stable_d;
    assign fall = ~stable & stable_d;
    assign hit  = (rise & rise_en) | (fall & fall_en);

    // Control registers; a new edge overrides a same-cycle W1C clear of its bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rise_en  <= '1;
            irq_mask <= '0;
            capture  <= '0;
            fall_en  <= '0;
        end else begin
            if (wr_en && addr_dec == ADDR_RISE_EN) begin
                rise_en <= wr_bits;
            end
            if (wr_en && addr_dec == ADDR_IRQ_MASK) begin
                irq_mask <= wr_bits;
            end
            if (wr_en && addr_dec == ADDR_FALL_EN) begin
                fall_en <= wr_bits;
            end
            if (wr_en && addr_dec == ADDR_CAPTURE) begin
                capture <= (capture & ~wr_bits) | hit;
            end else begin
                capture <= capture | hit;
            end
        end
    end

    // Read mux; unmapped addresses return zero
    always_comb begin
        rd_sel = '0;
        case (addr_dec)
            ADDR_DATA:     rd_sel = stable;
            ADDR_RISE_EN:  rd_sel = rise_en;
            ADDR_IRQ_MASK: rd_sel = irq_mask;
            ADDR_CAPTURE:  rd_sel = capture;
            ADDR_FALL_EN:  rd_sel = fall_en;
            default:       rd_sel = '0;
        endcase
    end

    // Registered read data, updated every cycle regardless of chipselect
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= 32'(rd_sel);
        end
    end

    assign irq = |(capture & irq_mask);

endmodule

// File: tb/tb_niosii_system_button_pio.sv
// Directed testbench for niosii_system_button_pio (WIDTH=8, SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4). Covers both builds via BUTTON_PIO_DEBOUNCE_EN.
module tb_niosii_system_button_pio;

`ifdef BUTTON_PIO_DEBOUNCE_EN
    localparam int DEB = 4;
`else
    localparam int DEB = 0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] readdata;
    logic        irq;
    logic [7:0]  pre;

    int n_tests = 0;
    int n_fail  = 0;

    niosii_system_button_pio #(
        .WIDTH(8),
        .SYNC_STAGES(2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .in_port(in_port),
        .readdata(readdata),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        cyc(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic rd_check(input string tag, input logic [2:0] a, input logic [31:0] exp);
        address = a;
        cyc(1);
        check(tag, readdata, exp);
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 8'h00;
        cyc(3);
        check("rst_readdata", readdata, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        reset_n = 1'b1;
        cyc(2);
        rd_check("rst_data", 3'd0, 32'h00);
        rd_check("rst_rise_en", 3'd1, 32'hFF);
        rd_check("rst_mask", 3'd2, 32'h00);
        rd_check("rst_capture", 3'd3, 32'h00);
        rd_check("rst_fall_en", 3'd4, 32'h00);

        // basic rising capture with irq
        wr(3'd2, 32'h01);
        in_port = 8'h01;
        cyc(10);
        check("t1_irq", {31'h0, irq}, 32'h1);
        rd_check("t1_capture", 3'd3, 32'h01);
        rd_check("t1_data", 3'd0, 32'h01);

        // W1C semantics
        wr(3'd3, 32'h01);
        check("t2_irq_clr", {31'h0, irq}, 32'h0);
        rd_check("t2_cap_clr", 3'd3, 32'h00);
        in_port = 8'h03;
        cyc(10);
        rd_check("t2_cap_b1", 3'd3, 32'h02);
        wr(3'd2, 32'h03);
        wr(3'd3, 32'h00);
        rd_check("t2_w0_keep", 3'd3, 32'h02);
        wr(3'd3, 32'h02);
        rd_check("t2_w1_bit", 3'd3, 32'h00);
        check("t2_irq_off", {31'h0, irq}, 32'h0);
        wr(3'd2, 32'h01);

        // falling-edge select
        wr(3'd1, 32'h00);
        wr(3'd4, 32'h80);
        in_port = 8'h83;
        cyc(10);
        rd_check("t3_rise_off", 3'd3, 32'h00);
        in_port = 8'h03;
        cyc(10);
        rd_check("t3_fall", 3'd3, 32'h80);
        check("t3_irq_masked", {31'h0, irq}, 32'h0);
        wr(3'd2, 32'h81);
        check("t3_irq_unmask", {31'h0, irq}, 32'h1);
        wr(3'd3, 32'h80);
        check("t3_irq_clr", {31'h0, irq}, 32'h0);
        in_port = 8'h83;
        cyc(10);
        rd_check("t3_no_rise", 3'd3, 32'h00);

        // same-cycle hit and W1C: set wins, other cleared bits still clear
        wr(3'd1, 32'h04);
        in_port = 8'h03;
        cyc(10);
        rd_check("t4_pre", 3'd3, 32'h80);
        in_port = 8'h07;
        cyc(2 + DEB);
        wr(3'd3, 32'h84);
        rd_check("t4_collide", 3'd3, 32'h04);

        // exact capture latency observed on irq
        wr(3'd3, 32'h04);
        wr(3'd2, 32'h08);
        wr(3'd1, 32'h0C);
        in_port = 8'h0F;
        cyc(2 + DEB);
        check("t4_lat_early", {31'h0, irq}, 32'h0);
        cyc(1);
        check("t4_lat_edge", {31'h0, irq}, 32'h1);
        rd_check("t4_data", 3'd0, 32'h0F);
        rd_check("t4_cap", 3'd3, 32'h08);

        // unmapped addresses
        wr(3'd5, 32'hFF);
        wr(3'd6, 32'hFF);
        wr(3'd7, 32'hFF);
        rd_check("t5_a5", 3'd5, 32'h0);
        rd_check("t5_a6", 3'd6, 32'h0);
        rd_check("t5_a7", 3'd7, 32'h0);
        rd_check("t5_rise", 3'd1, 32'h0C);
        rd_check("t5_mask", 3'd2, 32'h08);
        rd_check("t5_fall", 3'd4, 32'h80);

`ifdef BUTTON_PIO_DEBOUNCE_EN
        // glitch rejection and acceptance
        in_port = 8'h0D;
        cyc(12);
        wr(3'd3, 32'hFF);
        wr(3'd1, 32'hFF);
        in_port = 8'h0F;
        cyc(3);
        in_port = 8'h0D;
        cyc(12);
        rd_check("db_short_data", 3'd0, 32'h0D);
        rd_check("db_short_cap", 3'd3, 32'h00);
        in_port = 8'h0F;
        cyc(5);
        in_port = 8'h0D;
        cyc(3);
        rd_check("db_long_data", 3'd0, 32'h0F);
        rd_check("db_long_cap", 3'd3, 32'h02);
        cyc(12);
`endif

        // asynchronous reset mid-operation
        wr(3'd1, 32'hFF);
        wr(3'd4, 32'hFF);
        wr(3'd2, 32'hFF);
        pre = in_port;
        in_port = ~pre;
        cyc(12);
        rd_check("t6_cap_all", 3'd3, 32'hFF);
        check("t6_irq_on", {31'h0, irq}, 32'h1);
        in_port = pre;
        cyc(2);
        reset_n = 1'b0;
        #1;
        check("t6_rst_readdata", readdata, 32'h0);
        check("t6_rst_irq", {31'h0, irq}, 32'h0);
        cyc(2);
        reset_n = 1'b1;
        cyc(1);
        check("t6_cap_after", readdata, 32'h0);
        rd_check("t6_mask", 3'd2, 32'h00);
        rd_check("t6_rise", 3'd1, 32'hFF);
        rd_check("t6_fall", 3'd4, 32'h00);
        cyc(10);
        rd_check("t6_release_rise", 3'd3, {24'h0, pre});
        wr(3'd3, 32'hFF);
        rd_check("t6_sw_clear", 3'd3, 32'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
